// File: rtl/vcm_i2c_slave.sv
`timescale 1ns/1ps
// vcm_i2c_slave: I2C slave holding a 16-bit VCM focus word, written MSB byte then LSB byte.
// Define VCM_SLV_READBACK_EN to let the master read the word back (R/W=1).
module vcm_i2c_slave #(
    parameter logic [6:0] DEV_ADDR = 7'h0C
) (
    input  logic        CLK_50,
    input  logic        RESET_N,
    input  logic        I2C_SCL,
    inout  wire         I2C_SDA,
    output logic [15:0] VCM_DATA,
    output logic        VCM_WR,
    output logic        BUS_BUSY,
    output logic [7:0]  NACK_CNT
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_BYTE,
        WR_ACK,
        RD_BYTE,
        RD_ACK,
        IGNORE
    } state_t;

    state_t      state, state_n;
    logic [1:0]  scl_sync, sda_sync;
    logic        scl_d, sda_d;
    logic        scl_s, sda_s;
    logic        scl_rise, scl_fall, start, stop;
    logic [2:0]  bit_cnt, bit_cnt_n;
    logic        phase, phase_n;
    logic [7:0]  shreg, shreg_n;
    logic        ptr, ptr_n;
    logic [7:0]  shadow, shadow_n;
    logic        ack_ok, ack_ok_n;
    logic        sda_low, sda_low_n;
    logic [15:0] data_n;
    logic        wr_n, busy_n;
    logic [7:0]  nack_n;
    logic [7:0]  byte_in;
`ifdef VCM_SLV_READBACK_EN
    logic [15:0] snap, snap_n;
    logic        rd_sel, rd_sel_n;
    logic [7:0]  tx_byte, nx_byte;

    assign tx_byte = rd_sel ? snap[7:0] : snap[15:8];
    assign nx_byte = rd_sel ? snap[15:8] : snap[7:0];
`endif

    assign scl_s    = scl_sync[1];
    assign sda_s    = sda_sync[1];
    assign scl_rise = scl_s & ~scl_d;
    assign scl_fall = ~scl_s & scl_d;
    // Bus conditions need SCL stable high across the SDA transition.
    assign start    = scl_s & scl_d & sda_d & ~sda_s;
    assign stop     = scl_s & scl_d & ~sda_d & sda_s;
    assign byte_in  = {shreg[6:0], sda_s};
    assign I2C_SDA  = sda_low ? 1'b0 : 1'bz;

    always_ff @(posedge CLK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], I2C_SCL};
            sda_sync <= {sda_sync[0], I2C_SDA};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    always_ff @(posedge CLK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= IDLE;
            bit_cnt  <= 3'd0;
            phase    <= 1'b0;
            shreg    <= 8'h00;
            ptr      <= 1'b0;
            shadow   <= 8'h00;
            ack_ok   <= 1'b0;
            sda_low  <= 1'b0;
            VCM_DATA <= 16'h0000;
            VCM_WR   <= 1'b0;
            BUS_BUSY <= 1'b0;
            NACK_CNT <= 8'h00;
`ifdef VCM_SLV_READBACK_EN
            snap     <= 16'h0000;
            rd_sel   <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            phase    <= phase_n;
            shreg    <= shreg_n;
            ptr      <= ptr_n;
            shadow   <= shadow_n;
            ack_ok   <= ack_ok_n;
            sda_low  <= sda_low_n;
            VCM_DATA <= data_n;
            VCM_WR   <= wr_n;
            BUS_BUSY <= busy_n;
            NACK_CNT <= nack_n;
`ifdef VCM_SLV_READBACK_EN
            snap     <= snap_n;
            rd_sel   <= rd_sel_n;
`endif
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        phase_n   = phase;
        shreg_n   = shreg;
        ptr_n     = ptr;
        shadow_n  = shadow;
        ack_ok_n  = ack_ok;
        sda_low_n = sda_low;
        data_n    = VCM_DATA;
        wr_n      = 1'b0;
        busy_n    = BUS_BUSY;
        nack_n    = NACK_CNT;
`ifdef VCM_SLV_READBACK_EN
        snap_n    = snap;
        rd_sel_n  = rd_sel;
`endif
        if (stop) begin
            state_n   = IDLE;
            busy_n    = 1'b0;
            sda_low_n = 1'b0;
        end else if (start) begin
            state_n   = ADDR;
            busy_n    = 1'b1;
            sda_low_n = 1'b0;
            bit_cnt_n = 3'd0;
            phase_n   = 1'b0;
            ptr_n     = 1'b0;
        end else begin
            unique case (state)
                IDLE: sda_low_n = 1'b0;
                ADDR: begin
                    if (scl_rise) begin
                        shreg_n   = byte_in;
                        bit_cnt_n = bit_cnt + 3'd1;
                        phase_n   = 1'b0;
                        if (bit_cnt == 3'd7) begin
                            if (byte_in[7:1] == DEV_ADDR) begin
                                state_n  = ADDR_ACK;
`ifdef VCM_SLV_READBACK_EN
                                ack_ok_n = 1'b1;
                                snap_n   = VCM_DATA;
                                rd_sel_n = 1'b0;
`else
                                ack_ok_n = ~byte_in[0];
`endif
                            end else begin
                                state_n = IGNORE;
                                if (NACK_CNT != 8'hFF)
                                    nack_n = NACK_CNT + 8'd1;
                            end
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!phase) begin
                            sda_low_n = ack_ok;
                            phase_n   = 1'b1;
                        end else begin
                            sda_low_n = 1'b0;
                            phase_n   = 1'b0;
                            bit_cnt_n = 3'd0;
                            if (!ack_ok) begin
                                state_n = IGNORE;
                            end else if (shreg[0]) begin
`ifdef VCM_SLV_READBACK_EN
                                state_n   = RD_BYTE;
                                sda_low_n = ~snap[15];
`else
                                state_n   = IGNORE;
`endif
                            end else begin
                                state_n = WR_BYTE;
                            end
                        end
                    end
                end
                WR_BYTE: begin
                    if (scl_rise) begin
                        shreg_n   = byte_in;
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state_n = WR_ACK;
                            phase_n = 1'b0;
                            ptr_n   = ~ptr;
                            if (!ptr) begin
                                shadow_n = byte_in;
                            end else begin
                                data_n = {shadow, byte_in};
                                wr_n   = 1'b1;
                            end
                        end
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        if (!phase) begin
                            sda_low_n = 1'b1;
                            phase_n   = 1'b1;
                        end else begin
                            sda_low_n = 1'b0;
                            phase_n   = 1'b0;
                            state_n   = WR_BYTE;
                        end
                    end
                end
`ifdef VCM_SLV_READBACK_EN
                RD_BYTE: begin
                    if (scl_rise) begin
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            phase_n = 1'b1;
                    end else if (scl_fall) begin
                        if (phase) begin
                            sda_low_n = 1'b0;
                            phase_n   = 1'b0;
                            state_n   = RD_ACK;
                        end else begin
                            sda_low_n = ~tx_byte[3'd7 - bit_cnt];
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_s)
                            state_n = IGNORE;
                        else
                            phase_n = 1'b1;
                    end else if (scl_fall && phase) begin
                        phase_n   = 1'b0;
                        bit_cnt_n = 3'd0;
                        rd_sel_n  = ~rd_sel;
                        sda_low_n = ~nx_byte[7];
                        state_n   = RD_BYTE;
                    end
                end
`endif
                IGNORE: sda_low_n = 1'b0;
                default: begin
                    state_n   = IDLE;
                    sda_low_n = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vcm_i2c_slave.sv
`timescale 1ns/1ps
// tb_vcm_i2c_slave: bit-banged I2C master with a scoreboard of expected commits/read bytes.
module tb_vcm_i2c_slave;

    localparam int T = 8;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        scl   = 1'b1;
    logic        m_sda = 1'b1;
    wire         sda_bus;
    logic [15:0] vcm_data;
    logic        vcm_wr;
    logic        bus_busy;
    logic [7:0]  nack_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int rise_cyc = 0;
    int wr_cnt   = 0;
    int dut_low  = 0;

    logic [15:0] exp_wr_q[$];
    logic [7:0]  exp_rd_q[$];

    assign sda_bus = m_sda ? 1'bz : 1'b0;
    pullup (sda_bus);

    vcm_i2c_slave #(.DEV_ADDR(7'h0C)) dut (
        .CLK_50   (clk),
        .RESET_N  (rst_n),
        .I2C_SCL  (scl),
        .I2C_SDA  (sda_bus),
        .VCM_DATA (vcm_data),
        .VCM_WR   (vcm_wr),
        .BUS_BUSY (bus_busy),
        .NACK_CNT (nack_cnt)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Commits are checked against the queue and against the raw-SCL-to-commit latency.
    always @(posedge clk) begin
        #1;
        if (m_sda && !sda_bus) dut_low++;
        if (vcm_wr) begin
            wr_cnt++;
            chk("wr_latency", cyc - rise_cyc, 3);
            chk("wr_pending", exp_wr_q.size() != 0, 1);
            if (exp_wr_q.size() != 0)
                chk("wr_word", vcm_data, exp_wr_q.pop_front());
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_cycle(input logic b, output logic seen);
        m_sda = b;
        tick(T);
        scl = 1'b1;
        rise_cyc = cyc;
        tick(T / 2);
        seen = sda_bus;
        tick(T / 2);
        scl = 1'b0;
        tick(T);
    endtask

    task automatic i2c_start;
        m_sda = 1'b1;
        tick(T);
        scl = 1'b1;
        tick(T);
        m_sda = 1'b0;
        tick(T);
        scl = 1'b0;
        tick(T);
    endtask

    task automatic i2c_stop;
        m_sda = 1'b0;
        tick(T);
        scl = 1'b1;
        tick(T);
        m_sda = 1'b1;
        tick(2 * T);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_cycle(b[i], s);
        bit_cycle(1'b1, s);
        ack = ~s;
    endtask

    task automatic recv_byte(input logic m_ack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_cycle(1'b1, s);
            b[i] = s;
        end
        bit_cycle(m_ack, s);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ack;
        logic [7:0] rb;
        int         w0;

        rst_n = 1'b0;
        tick(5);
        chk("rst_data", vcm_data, 16'h0000);
        chk("rst_wr", vcm_wr, 1'b0);
        chk("rst_busy", bus_busy, 1'b0);
        chk("rst_nack", nack_cnt, 8'h00);
        chk("rst_sda", sda_bus, 1'b1);
        rst_n = 1'b1;
        tick(5);

        // Bus activity with no START must be ignored.
        dut_low = 0;
        w0 = wr_cnt;
        scl = 1'b0;
        tick(T);
        send_byte(8'h18, ack);
        scl = 1'b1;
        tick(T);
        chk("nostart_ack", ack, 1'b0);
        chk("nostart_busy", bus_busy, 1'b0);
        chk("nostart_drive", dut_low, 0);
        chk("nostart_pulses", wr_cnt - w0, 0);

        // Plain write.
        w0 = wr_cnt;
        i2c_start;
        chk("wr_busy", bus_busy, 1'b1);
        exp_wr_q.push_back(16'h3FA0);
        send_byte(8'h18, ack);
        chk("wr_ack_addr", ack, 1'b1);
        send_byte(8'h3F, ack);
        chk("wr_ack_msb", ack, 1'b1);
        send_byte(8'hA0, ack);
        chk("wr_ack_lsb", ack, 1'b1);
        i2c_stop;
        chk("wr_data", vcm_data, 16'h3FA0);
        chk("wr_pulses", wr_cnt - w0, 1);
        chk("wr_busy_after", bus_busy, 1'b0);

        // Wrong address.
        dut_low = 0;
        i2c_start;
        send_byte(8'h1A, ack);
        chk("bad_ack_addr", ack, 1'b0);
        send_byte(8'h55, ack);
        chk("bad_ack_data", ack, 1'b0);
        i2c_stop;
        chk("bad_drive", dut_low, 0);
        chk("bad_data", vcm_data, 16'h3FA0);
        chk("bad_nack_cnt", nack_cnt, 8'h01);

        // Odd byte count is discarded; next transfer starts at the MSB.
        w0 = wr_cnt;
        i2c_start;
        send_byte(8'h18, ack);
        send_byte(8'h12, ack);
        i2c_stop;
        chk("part_keep", vcm_data, 16'h3FA0);
        exp_wr_q.push_back(16'h3456);
        i2c_start;
        send_byte(8'h18, ack);
        send_byte(8'h34, ack);
        send_byte(8'h56, ack);
        i2c_stop;
        chk("part_data", vcm_data, 16'h3456);
        chk("part_pulses", wr_cnt - w0, 1);

        // Repeated START restarts the byte pairing.
        exp_wr_q.push_back(16'h0203);
        i2c_start;
        send_byte(8'h18, ack);
        send_byte(8'h01, ack);
        i2c_start;
        send_byte(8'h18, ack);
        chk("rs_ack_addr", ack, 1'b1);
        send_byte(8'h02, ack);
        send_byte(8'h03, ack);
        i2c_stop;
        chk("rs_data", vcm_data, 16'h0203);

        // Readback.
        exp_wr_q.push_back(16'h3FA0);
        i2c_start;
        send_byte(8'h18, ack);
        send_byte(8'h3F, ack);
        send_byte(8'hA0, ack);
        i2c_stop;
        i2c_start;
        send_byte(8'h19, ack);
`ifdef VCM_SLV_READBACK_EN
        chk("rd_ack_addr", ack, 1'b1);
        exp_rd_q.push_back(8'h3F);
        exp_rd_q.push_back(8'hA0);
        recv_byte(1'b0, rb);
        chk("rd_byte0", rb, exp_rd_q.pop_front());
        recv_byte(1'b1, rb);
        chk("rd_byte1", rb, exp_rd_q.pop_front());
        i2c_stop;
        chk("rd_busy_after", bus_busy, 1'b0);
`else
        chk("rd_addr_nack", ack, 1'b0);
        i2c_stop;
        chk("rd_nack_cnt", nack_cnt, 8'h01);
        rb = 8'h00;
        chk("rd_data_keep", vcm_data, 16'h3FA0);
`endif

        // Reset after the MSB byte of a write.
        w0 = wr_cnt;
        i2c_start;
        send_byte(8'h18, ack);
        send_byte(8'h3F, ack);
        rst_n = 1'b0;
        tick(4);
        chk("mrst_data", vcm_data, 16'h0000);
        chk("mrst_wr", vcm_wr, 1'b0);
        chk("mrst_busy", bus_busy, 1'b0);
        chk("mrst_nack", nack_cnt, 8'h00);
        chk("mrst_sda", sda_bus, 1'b1);
        rst_n = 1'b1;
        tick(T);
        send_byte(8'hA0, ack);
        chk("mrst_resume_ack", ack, 1'b0);
        i2c_stop;
        chk("mrst_no_commit", wr_cnt - w0, 0);
        exp_wr_q.push_back(16'h1234);
        i2c_start;
        send_byte(8'h18, ack);
        chk("mrst_new_ack", ack, 1'b1);
        send_byte(8'h12, ack);
        send_byte(8'h34, ack);
        i2c_stop;
        chk("mrst_new_data", vcm_data, 16'h1234);
        chk("mrst_pulses", wr_cnt - w0, 1);

        tick(10);
        chk("wr_q_empty", exp_wr_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
